// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sd_pkg
// Brief    : Shared constants and helpers for the sigma-delta CIC decimator.
// Revision : 1.0
// ============================================================================
package sd_pkg;

   localparam int CIC_ORDER = 3;

   // Bit growth of a 3rd-order CIC fed with a 3-bit sample: 3 + ORDER*log2(R).
   function automatic int cic_width(input int decim);
      return 3 + CIC_ORDER * $clog2(decim);
   endfunction

   function automatic logic signed [2:0] sd_map(input logic [1:0] bits);
      logic signed [2:0] s;
      case (bits)
         2'b00:   s = -3'sd2;
         2'b11:   s = 3'sd2;
         default: s = 3'sd0;
      endcase
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sd_cic_comb.sv
`default_nettype none
// ============================================================================
// Module   : sd_cic_comb
// Brief    : One CIC comb stage; the delay register captures x when advanced.
// Revision : 1.0
// ============================================================================
module sd_cic_comb #(
   parameter int WIDTH = 21
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             advance,
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y
);

   logic [WIDTH-1:0] dly_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         dly_q <= '0;
      end else if (advance) begin
         dly_q <= x;
      end
   end

   assign y = x - dly_q;

endmodule
`default_nettype wire

// File: rtl/sd_decimator.sv
`default_nettype none
// ============================================================================
// Module   : sd_decimator
// Brief    : 3rd-order CIC decimator for the 2-bit sigma-delta bitstream.
// Revision : 1.0
// ============================================================================
module sd_decimator
   import sd_pkg::*;
#(
   parameter int DECIM    = 64,
   parameter int BITWIDTH = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic [1:0]          sd_in,
   output logic [BITWIDTH-1:0] out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                overrun
);

   localparam int W     = cic_width(DECIM);
   localparam int CNT_W = $clog2(DECIM);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

   logic [W-1:0]        s_ext;
   logic [W-1:0]        i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                strobe;
   logic                stb_q, v1_q, v2_q;
   logic [W-1:0]        c1_q, c2_q;
   logic [W-1:0]        comb_x [CIC_ORDER];
   logic [W-1:0]        comb_y [CIC_ORDER];
   logic                comb_adv [CIC_ORDER];
   logic [BITWIDTH-1:0] out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;
   logic                overrun_q, overrun_d;

   assign s_ext  = W'(sd_map(sd_in));
   assign strobe = en && (cnt_q == CNT_LAST);

   always_comb begin
      i1_d  = i1_q;
      i2_d  = i2_q;
      i3_d  = i3_q;
      cnt_d = cnt_q;
      if (en) begin
         i1_d  = i1_q + s_ext;
         i2_d  = i2_q + i1_d;
         i3_d  = i3_q + i2_d;
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   // i3_q holds the strobed I3 value during the cycle after the strobe edge.
   assign comb_x[0]   = i3_q;
   assign comb_x[1]   = c1_q;
   assign comb_x[2]   = c2_q;
   assign comb_adv[0] = stb_q;
   assign comb_adv[1] = v1_q;
   assign comb_adv[2] = v2_q;

   for (genvar k = 0; k < CIC_ORDER; k++) begin : g_comb
      sd_cic_comb #(.WIDTH(W)) u_comb (
         .clk     (clk),
         .reset   (reset),
         .advance (comb_adv[k]),
         .x       (comb_x[k]),
         .y       (comb_y[k])
      );
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      overrun_d   = overrun_q;
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      if (v2_q) begin
         if (!out_valid_q || out_ready) begin
            out_data_d  = BITWIDTH'($signed(comb_y[2]));
            out_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         i1_q        <= '0;
         i2_q        <= '0;
         i3_q        <= '0;
         cnt_q       <= '0;
         stb_q       <= 1'b0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         c1_q        <= '0;
         c2_q        <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         i1_q        <= i1_d;
         i2_q        <= i2_d;
         i3_q        <= i3_d;
         cnt_q       <= cnt_d;
         stb_q       <= strobe;
         v1_q        <= stb_q;
         v2_q        <= v1_q;
         if (stb_q) c1_q <= comb_y[0];
         if (v1_q)  c2_q <= comb_y[1];
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_decimator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_decimator
// Brief    : Directed scoreboard bench for sd_decimator at DECIM=64, 32-bit out.
// Revision : 1.0
// ============================================================================
module tb_sd_decimator;

   localparam int DECIM    = 64;
   localparam int BITWIDTH = 32;
   localparam logic [31:0] DC_POS  = 32'd524288;
   localparam logic [31:0] DC_NEG  = 32'hFFF8_0000;
   // First sample after reset for constant +2 input: I3(64) = 64*65*66/3.
   localparam logic [31:0] FIRST_P = 32'd91520;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                en = 1'b0;
   logic [1:0]          sd_in = 2'b00;
   logic                out_ready = 1'b0;
   logic [BITWIDTH-1:0] out_data;
   logic                out_valid;
   logic                overrun;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          n_xfer   = 0;
   int          skip     = 0;
   int          cyc      = 0;
   int          t_last   = 0;
   int          t_prev   = 0;
   int          pat      = 0;
   int          en_mode  = 0;
   logic [1:0]  const_val = 2'b11;
   logic        phase    = 1'b0;
   logic [31:0] exp_v;
   logic [31:0] sb [$];

   sd_decimator #(.DECIM(DECIM), .BITWIDTH(BITWIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .sd_in     (sd_in),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      case (pat)
         1:       sd_in = phase ? 2'b01 : 2'b10;
         2:       sd_in = phase ? 2'b11 : 2'b00;
         default: sd_in = const_val;
      endcase
      en = (en_mode == 1) ? phase : 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      phase = ~phase;
      drive();
   endtask

   task automatic do_reset(input int p, input logic [1:0] c, input int em);
      reset     = 1'b0;
      pat       = p;
      const_val = c;
      en_mode   = em;
      sb.delete();
      skip      = 0;
      tick();
      tick();
      reset = 1'b1;
      phase = 1'b0;
      drive();
   endtask

   task automatic wait_xfers(input int n, input int budget);
      int target;
      target = n_xfer + n;
      for (int i = 0; i < budget && n_xfer < target; i++) tick();
      check("xfer_count", n_xfer, target);
   endtask

   // Transfers happen on the next rising edge; the first 'skip' are transients.
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         n_xfer++;
         t_prev = t_last;
         t_last = cyc;
         if (skip > 0) begin
            skip--;
         end else if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            check("sample", out_data, exp_v);
         end
      end
   end

   initial begin
      // Reset state
      tick(); tick(); tick();
      check("rst_data", out_data, 32'd0);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);

      // Constant 11, continuous enable
      out_ready = 1'b1;
      do_reset(0, 2'b11, 0);
      skip = 3;
      repeat (5) sb.push_back(DC_POS);
      wait_xfers(8, 8 * DECIM + 40);
      check("sb_empty_pos", sb.size(), 0);
      check("spacing_cont", t_last - t_prev, DECIM);
      check("overrun_pos", {31'd0, overrun}, 32'd0);

      // Constant 00
      do_reset(0, 2'b00, 0);
      skip = 3;
      repeat (5) sb.push_back(DC_NEG);
      wait_xfers(8, 8 * DECIM + 40);
      check("sb_empty_neg", sb.size(), 0);

      // Alternating 01/10
      do_reset(1, 2'b00, 0);
      skip = 3;
      repeat (5) sb.push_back(32'd0);
      wait_xfers(8, 8 * DECIM + 40);
      check("sb_empty_alt", sb.size(), 0);

      // Repeating 11,00
      do_reset(2, 2'b00, 0);
      skip = 3;
      repeat (5) sb.push_back(32'd0);
      wait_xfers(8, 8 * DECIM + 40);
      check("sb_empty_1100", sb.size(), 0);

      // en toggled every cycle
      do_reset(0, 2'b11, 1);
      skip = 3;
      repeat (5) sb.push_back(DC_POS);
      wait_xfers(8, 16 * DECIM + 80);
      check("sb_empty_entog", sb.size(), 0);
      check("spacing_entog", t_last - t_prev, 2 * DECIM);

      // Consumer stall across two results
      out_ready = 1'b0;
      do_reset(0, 2'b11, 0);
      for (int i = 0; i < DECIM + 10 && !out_valid; i++) tick();
      check("ovr_valid1", {31'd0, out_valid}, 32'd1);
      check("ovr_first", out_data, FIRST_P);
      check("ovr_clear", {31'd0, overrun}, 32'd0);
      for (int i = 0; i < DECIM + 10 && !overrun; i++) tick();
      check("ovr_set", {31'd0, overrun}, 32'd1);
      check("ovr_hold", out_data, FIRST_P);
      check("ovr_valid_hold", {31'd0, out_valid}, 32'd1);
      skip = 0;
      sb.push_back(FIRST_P);
      sb.push_back(DC_POS);
      out_ready = 1'b1;
      wait_xfers(2, 2 * DECIM + 20);
      check("ovr_sticky", {31'd0, overrun}, 32'd1);
      check("sb_empty_ovr", sb.size(), 0);

      // Reset two cycles after a strobe kills the in-flight result
      do_reset(0, 2'b11, 0);
      skip = 1000;
      repeat (DECIM) tick();
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check("rstmid_valid", {31'd0, out_valid}, 32'd0);
      check("rstmid_data", out_data, 32'd0);
      repeat (DECIM + 1) tick();
      check("rstmid_early", {31'd0, out_valid}, 32'd0);
      tick();
      check("rstmid_restart", {31'd0, out_valid}, 32'd1);
      check("rstmid_sample", out_data, FIRST_P);
      skip = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
